pipeline_deliver_queue: RTL and testbench

Parametrised elastic pipeline stage between decode and ROB allocation. It replaces the per-field flop bank with a DEPTH-entry circular queue over one packed WIDTH-bit payload. Valid/ready handshakes on both sides replace the stall_current_stage/stall_next_stage pair. Decode keeps issuing while the ROB is briefly stalled; flush discards all queued instructions.

---
 rtl/pipeline_deliver_queue.sv | 93 +++++++++
 tb/tb_pipeline_deliver_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_deliver_queue.sv
// rtl/pipeline_deliver_queue.sv - elastic decode->ROB queue, DEPTH-entry circular buffer
// Optional zero-latency cut-through when empty: define IDQ_BYPASS_EN.
module pipeline_deliver_queue #(
  parameter int WIDTH              = 160,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             bypass;
  logic             push;
  logic             pop;

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(ALMOST_FULL_THRESH));

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready = !full;

`ifdef IDQ_BYPASS_EN
  assign bypass = empty && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid && in_ready && !bypass;
  assign pop  = !empty && out_ready;

  assign out_valid = !empty || bypass;

  always_comb begin
    out_data = '0;
    if (bypass) begin
      out_data = in_data;
    end else if (!empty) begin
      out_data = mem[rd_ptr];
    end
  end

  // Storage is intentionally not reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_deliver_queue.sv
// tb/tb_pipeline_deliver_queue.sv - scoreboard bench for pipeline_deliver_queue
module tb_pipeline_deliver_queue;
  localparam int WIDTH = 160;
  localparam int DEPTH = 4;
  localparam int AFT   = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef IDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_full;

  pipeline_deliver_queue #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(AFT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] sb_q [$];
  int exp_count = 0;
  bit p_enq = 1'b0, p_deq = 1'b0, p_fl = 1'b0, exp_ov = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: occupancy counter plus an ordered list of accepted payloads.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
    bit byp;
    @(posedge clk);
    #1;
    if (p_fl) exp_count = 0;
    else exp_count = exp_count + int'(p_enq) - int'(p_deq);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    byp    = BYP && (exp_count == 0) && iv && ordy && !fl;
    exp_ov = (exp_count > 0) || byp;
    p_fl   = fl;
    p_enq  = iv && (exp_count < DEPTH) && !byp;
    p_deq  = (exp_count > 0) && ordy;
    if (fl) sb_q.delete();
    else if (iv && exp_count < DEPTH) sb_q.push_back(d);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("count", WIDTH'(count), WIDTH'(exp_count));
      chk("empty", WIDTH'(empty), WIDTH'(exp_count == 0));
      chk("full", WIDTH'(full), WIDTH'(exp_count == DEPTH));
      chk("almost_full", WIDTH'(almost_full), WIDTH'(exp_count >= AFT));
      chk("in_ready", WIDTH'(in_ready), WIDTH'(exp_count < DEPTH));
      chk("out_valid", WIDTH'(out_valid), WIDTH'(exp_ov));
      if (!exp_ov) chk("out_data_zero", out_data, '0);
      if (out_valid && out_ready && !flush) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", out_data, 'x);
        end else begin
          chk("out_data", out_data, sb_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, WIDTH'(count), '0);
    chk({tag, "_out_valid"}, WIDTH'(out_valid), '0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
    chk({tag, "_empty"}, WIDTH'(empty), WIDTH'(1));
    chk({tag, "_full"}, WIDTH'(full), '0);
    chk({tag, "_almost_full"}, WIDTH'(almost_full), '0);
  endtask

  initial begin
    logic [WIDTH-1:0] pat_a5;
    pat_a5 = {20{8'hA5}};
    #12;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Fill and hold, fifth offer refused.
    for (int i = 1; i <= 5; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Continuous streaming.
    for (int i = 0; i < 20; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Pointer wrap-around.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) cycle(1'b1, WIDTH'(100 + r * 3 + k), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    end

    // Flush with simultaneous enqueue and dequeue.
    cycle(1'b1, WIDTH'(32'h11), 1'b0, 1'b0);
    cycle(1'b1, WIDTH'(32'h22), 1'b0, 1'b0);
    cycle(1'b1, WIDTH'(32'h33), 1'b1, 1'b1);
    cycle(1'b1, WIDTH'(32'h77), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Cut-through or single-entry path from empty.
    cycle(1'b1, WIDTH'(32'h3C), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, WIDTH'(32'h3C), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_payload(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_count = 0;
    p_enq = 1'b0; p_deq = 1'b0; p_fl = 1'b0; exp_ov = 1'b0;
    sb_q.delete();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    cycle(1'b1, pat_a5, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_payload(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("sb_drained", WIDTH'(sb_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
